// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM: port A byte-masked write, port B pipelined read with valid strobe.
// Latency: read data and dvalb are registered READ_LATENCY edges after the accepting edge, counting that edge as the first.
// Backpressure: none; a read is accepted every READY cycle, and both ports are ignored while init_busy is high.
module sdp_ram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 2,
  parameter int WR_FIRST       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wena,
  input  logic [ADDR_WIDTH-1:0]     addra,
  input  logic [DATA_WIDTH-1:0]     dina,
  input  logic [DATA_WIDTH/8-1:0]   bea,
  input  logic                      renb,
  input  logic [ADDR_WIDTH-1:0]     addrb,
  output logic [DATA_WIDTH-1:0]     doutb,
  output logic                      dvalb,
  output logic                      init_busy
);

  localparam int NB = DATA_WIDTH / 8;
  // Index width sized to the real array so narrow memories do not carry dead address bits.
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [IW-1:0]       LAST_PTR = IW'(MEM_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state_q;
  logic [IW-1:0]           ptr_q;
  logic                    init_busy_q;

  logic [DATA_WIDTH-1:0]   mem [0:MEM_DEPTH-1];

  logic                    wa_in_range;
  logic                    rb_in_range;
  logic [IW-1:0]           wa_idx;
  logic [IW-1:0]           rb_idx;
  logic                    ready;
  logic                    wr_ok;
  logic                    rd_acc;
  logic                    collide;
  logic [DATA_WIDTH-1:0]   rd_dat_d;

  logic                    pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_dat;
  logic                    dvalb_q;
  logic [DATA_WIDTH-1:0]   doutb_q;

  assign wa_in_range = ({1'b0, addra} < DEPTH_C);
  assign rb_in_range = ({1'b0, addrb} < DEPTH_C);
  assign wa_idx      = addra[IW-1:0];
  assign rb_idx      = addrb[IW-1:0];

  // Ports only act on a non-reset edge once the clear sweep has finished.
  assign ready   = rst && (state_q == ST_READY);
  assign wr_ok   = ready && wena && wa_in_range;
  assign rd_acc  = ready && renb;
  assign collide = wr_ok && (addra == addrb);

  // Clear-sweep controller: INIT walks the pointer over every word, then parks in READY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      ptr_q       <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      unique case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + IW'(1);
          if (ptr_q == LAST_PTR) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
        default: begin
          state_q <= ST_READY;
        end
      endcase
    end
  end

  // Array update: sweep zeroes one word per cycle, otherwise byte-masked port A writes.
  always_ff @(posedge clk) begin
    if (rst && (state_q == ST_INIT)) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (bea[b]) begin
          mem[wa_idx][8*b +: 8] <= dina[8*b +: 8];
        end
      end
    end
  end

  // Read word selection: out-of-range returns zero; write-first merges same-edge write bytes.
  always_comb begin
    rd_dat_d = '0;
    if (rb_in_range) begin
      rd_dat_d = mem[rb_idx];
    end
    if ((WR_FIRST != 0) && collide) begin
      for (int b = 0; b < NB; b++) begin
        if (bea[b]) begin
          rd_dat_d[8*b +: 8] = dina[8*b +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      // With a single stage the array read feeds the output register directly.
      assign pipe_vld = rd_acc;
      assign pipe_dat = rd_dat_d;
    end else begin : g_latn
      logic [READ_LATENCY-2:0]                 p_vld_q;
      logic [READ_LATENCY-2:0][DATA_WIDTH-1:0] p_dat_q;

      // Array-read stage plus intermediate stages carrying data and valid together.
      always_ff @(posedge clk) begin
        if (!rst) begin
          p_vld_q <= '0;
          p_dat_q <= '0;
        end else begin
          p_vld_q[0] <= rd_acc;
          p_dat_q[0] <= rd_dat_d;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            p_vld_q[i] <= p_vld_q[i-1];
            p_dat_q[i] <= p_dat_q[i-1];
          end
        end
      end

      assign pipe_vld = p_vld_q[READ_LATENCY-2];
      assign pipe_dat = p_dat_q[READ_LATENCY-2];
    end
  endgenerate

  // Output stage: strobe follows the pipe, data only moves on a valid so it holds between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dvalb_q <= 1'b0;
      doutb_q <= '0;
    end else begin
      dvalb_q <= pipe_vld;
      if (pipe_vld) begin
        doutb_q <= pipe_dat;
      end
    end
  end

  assign doutb     = doutb_q;
  assign dvalb     = dvalb_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Directed bench for sdp_ram_pipe: two instances (write-first and read-first), 16 words, 3-cycle read latency.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Each scenario task makes its own comparisons; a single summary line ends the run.
module tb_sdp_ram_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wena;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [3:0]    bea;
  logic          renb;
  logic [AW-1:0] addrb;

  logic [DW-1:0] doutb_a, doutb_b;
  logic          dvalb_a, dvalb_b;
  logic          busy_a, busy_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            first_a;
  int            last_a;
  bit            contig_a;

  always #5 clk = ~clk;

  sdp_ram_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(16),
    .READ_LATENCY(L), .WR_FIRST(1), .CLEAR_ON_RESET(1)
  ) u_wf (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bea(bea),
    .renb(renb), .addrb(addrb), .doutb(doutb_a), .dvalb(dvalb_a), .init_busy(busy_a)
  );

  sdp_ram_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(16),
    .READ_LATENCY(L), .WR_FIRST(0), .CLEAR_ON_RESET(1)
  ) u_rf (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bea(bea),
    .renb(renb), .addrb(addrb), .doutb(doutb_b), .dvalb(dvalb_b), .init_busy(busy_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    wena  = 1'b1;
    addra = a;
    dina  = d;
    bea   = be;
    tick();
    wena  = 1'b0;
    bea   = 4'h0;
  endtask

  // Issue n back-to-back reads from start and collect every strobed word from both instances.
  task automatic stream(input logic [AW-1:0] start, input int n);
    qa.delete();
    qb.delete();
    first_a  = -1;
    last_a   = -1;
    contig_a = 1'b1;
    for (int c = 0; c < n + L + 2; c++) begin
      renb  = (c < n);
      addrb = start + AW'(c);
      tick();
      if (dvalb_a) begin
        if (first_a < 0) first_a = c;
        else if (c != last_a + 1) contig_a = 1'b0;
        last_a = c;
        qa.push_back(doutb_a);
      end
      if (dvalb_b) qb.push_back(doutb_b);
    end
    renb = 1'b0;
  endtask

  task automatic test_reset_clear;
    int cnt;
    int nz;
    bit saw;
    rst = 1'b0;
    repeat (3) tick();
    tot_cnt++; if (dvalb_a !== 1'b0) $display("FAIL reset_dvalb: got %b want 0", dvalb_a); else pass_cnt++;
    tot_cnt++; if (doutb_a !== 32'h0) $display("FAIL reset_doutb: got %h want 00000000", doutb_a); else pass_cnt++;
    tot_cnt++; if (busy_a !== 1'b1) $display("FAIL reset_init_busy: got %b want 1", busy_a); else pass_cnt++;
    rst = 1'b1;
    cnt = 0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a !== 1'b1) break;
      cnt++;
      renb  = (i == 3);
      addrb = 5'd1;
      wena  = (i == 10);
      addra = 5'd0;
      dina  = 32'h0000CAFE;
      bea   = 4'hF;
      tick();
      if (dvalb_a || dvalb_b) saw = 1'b1;
    end
    renb = 1'b0;
    wena = 1'b0;
    bea  = 4'h0;
    repeat (4) begin
      tick();
      if (dvalb_a || dvalb_b) saw = 1'b1;
    end
    tot_cnt++; if (cnt != 16) $display("FAIL sweep_cycles: got %0d want 16", cnt); else pass_cnt++;
    tot_cnt++; if (saw) $display("FAIL init_read_ignored: got dvalb=1 want none"); else pass_cnt++;
    stream(5'd0, 16);
    nz = 0;
    foreach (qa[i]) if (qa[i] !== 32'h0) nz++;
    foreach (qb[i]) if (qb[i] !== 32'h0) nz++;
    tot_cnt++; if (qa.size() != 16 || qb.size() != 16) $display("FAIL clear_read_count: got %0d/%0d want 16/16", qa.size(), qb.size()); else pass_cnt++;
    tot_cnt++; if (nz != 0) $display("FAIL clear_contents: got %0d nonzero words want 0", nz); else pass_cnt++;
  endtask

  task automatic test_latency;
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    renb  = 1'b1;
    addrb = 5'd5;
    tick();
    renb  = 1'b0;
    tot_cnt++; if (dvalb_a !== 1'b0) $display("FAIL lat_T: got %b want 0", dvalb_a); else pass_cnt++;
    tick();
    tot_cnt++; if (dvalb_a !== 1'b0) $display("FAIL lat_T1: got %b want 0", dvalb_a); else pass_cnt++;
    tick();
    tot_cnt++; if (dvalb_a !== 1'b1) $display("FAIL lat_T2_valid: got %b want 1", dvalb_a); else pass_cnt++;
    tot_cnt++; if (doutb_a !== 32'hDEADBEEF) $display("FAIL lat_T2_data: got %h want deadbeef", doutb_a); else pass_cnt++;
    tick();
    tot_cnt++; if (dvalb_a !== 1'b0) $display("FAIL lat_T3_valid: got %b want 0", dvalb_a); else pass_cnt++;
    tot_cnt++; if (doutb_a !== 32'hDEADBEEF) $display("FAIL lat_hold: got %h want deadbeef", doutb_a); else pass_cnt++;
  endtask

  task automatic test_byte_enable;
    wr(5'd7, 32'h11223344, 4'hF);
    wr(5'd7, 32'hAABBCCDD, 4'b0101);
    stream(5'd7, 1);
    tot_cnt++; if (qa.size() != 1 || qa[0] !== 32'h11BB33DD) $display("FAIL be_merge: got %h want 11bb33dd", qa[0]); else pass_cnt++;
    wr(5'd7, 32'hFFFFFFFF, 4'h0);
    stream(5'd7, 1);
    tot_cnt++; if (qb.size() != 1 || qb[0] !== 32'h11BB33DD) $display("FAIL be_zero: got %h want 11bb33dd", qb[0]); else pass_cnt++;
  endtask

  task automatic test_out_of_range;
    wr(5'd4, 32'h44444444, 4'hF);
    wr(5'd20, 32'h12345678, 4'hF);
    stream(5'd4, 1);
    tot_cnt++; if (qa.size() != 1 || qa[0] !== 32'h44444444) $display("FAIL oor_write_dropped: got %h want 44444444", qa[0]); else pass_cnt++;
    stream(5'd20, 1);
    tot_cnt++; if (qa.size() != 1) $display("FAIL oor_read_valid: got %0d strobes want 1", qa.size()); else pass_cnt++;
    tot_cnt++; if (qa[0] !== 32'h0) $display("FAIL oor_read_zero: got %h want 00000000", qa[0]); else pass_cnt++;
  endtask

  task automatic test_collision;
    wr(5'd9, 32'h00000001, 4'hF);
    wena = 1'b1; addra = 5'd9; dina = 32'h000000FF; bea = 4'hF;
    renb = 1'b1; addrb = 5'd9;
    tick();
    wena = 1'b0; bea = 4'h0; renb = 1'b0;
    tick();
    tick();
    tot_cnt++; if (dvalb_a !== 1'b1 || doutb_a !== 32'h000000FF) $display("FAIL coll_write_first: got %b/%h want 1/000000ff", dvalb_a, doutb_a); else pass_cnt++;
    tot_cnt++; if (dvalb_b !== 1'b1 || doutb_b !== 32'h00000001) $display("FAIL coll_read_first: got %b/%h want 1/00000001", dvalb_b, doutb_b); else pass_cnt++;
    stream(5'd9, 1);
    tot_cnt++; if (qa[0] !== 32'h000000FF || qb[0] !== 32'h000000FF) $display("FAIL coll_after: got %h/%h want 000000ff", qa[0], qb[0]); else pass_cnt++;
    wena = 1'b1; addra = 5'd9; dina = 32'h0000AB00; bea = 4'b0010;
    renb = 1'b1; addrb = 5'd9;
    tick();
    wena = 1'b0; bea = 4'h0; renb = 1'b0;
    tick();
    tick();
    tot_cnt++; if (doutb_a !== 32'h0000ABFF || doutb_b !== 32'h000000FF) $display("FAIL coll_partial: got %h/%h want 0000abff/000000ff", doutb_a, doutb_b); else pass_cnt++;
    wena = 1'b1; addra = 5'd10; dina = 32'h00000077; bea = 4'hF;
    renb = 1'b1; addrb = 5'd9;
    tick();
    wena = 1'b0; bea = 4'h0; renb = 1'b0;
    tick();
    tick();
    tot_cnt++; if (doutb_a !== 32'h0000ABFF || doutb_b !== 32'h0000ABFF) $display("FAIL coll_diff_addr: got %h/%h want 0000abff", doutb_a, doutb_b); else pass_cnt++;
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(i * 3), 4'hF);
    stream(5'd0, 8);
    tot_cnt++; if (qa.size() != 8) $display("FAIL stream_count: got %0d want 8", qa.size()); else pass_cnt++;
    tot_cnt++; if (first_a != L - 1) $display("FAIL stream_first: got cycle %0d want %0d", first_a, L - 1); else pass_cnt++;
    tot_cnt++; if (!contig_a) $display("FAIL stream_contig: got gaps want back-to-back"); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tot_cnt++;
      if (qa[i] !== DW'(i * 3)) $display("FAIL stream_data[%0d]: got %h want %h", i, qa[i], DW'(i * 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_read;
    int cnt;
    bit saw;
    renb  = 1'b1;
    addrb = 5'd7;
    tick();
    renb = 1'b0;
    rst  = 1'b0;
    tick();
    tot_cnt++; if (dvalb_a !== 1'b0) $display("FAIL mid_rst_dvalb: got %b want 0", dvalb_a); else pass_cnt++;
    tot_cnt++; if (doutb_a !== 32'h0) $display("FAIL mid_rst_doutb: got %h want 00000000", doutb_a); else pass_cnt++;
    tot_cnt++; if (busy_a !== 1'b1) $display("FAIL mid_rst_busy: got %b want 1", busy_a); else pass_cnt++;
    rst = 1'b1;
    cnt = 0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a !== 1'b1) break;
      cnt++;
      tick();
      if (dvalb_a || dvalb_b) saw = 1'b1;
    end
    tot_cnt++; if (cnt != 16 || saw) $display("FAIL mid_rst_sweep: got %0d cycles dvalb_seen=%b want 16/0", cnt, saw); else pass_cnt++;
    stream(5'd7, 1);
    tot_cnt++; if (qa.size() != 1 || qa[0] !== 32'h0) $display("FAIL mid_rst_addr7: got %h want 00000000", qa[0]); else pass_cnt++;
    stream(5'd5, 1);
    tot_cnt++; if (qb.size() != 1 || qb[0] !== 32'h0) $display("FAIL mid_rst_addr5: got %h want 00000000", qb[0]); else pass_cnt++;
  endtask

  initial begin
    rst   = 1'b0;
    wena  = 1'b0;
    addra = '0;
    dina  = '0;
    bea   = '0;
    renb  = 1'b0;
    addrb = '0;
    test_reset_clear();
    test_latency();
    test_byte_enable();
    test_out_of_range();
    test_collision();
    test_streaming();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
